// File: rtl/sar_logic.sv
// Successive-approximation controller for the 9-bit SAR ADC: sample phase,
// MSB-first switch-word search driven by the comparator, one-cycle FINAL strobe.
module sar_logic #(
    parameter int NBIT       = 9,
    parameter int SAMPLE_CYC = 2
) (
    input  logic            CKS,
    input  logic            RST,
    input  logic            EN,
    input  logic            CMP,
    output logic            SMP,
    output logic [0:NBIT-1] SWP,
    output logic            FINAL,
    output logic            BUSY
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SAMPLE = 2'd1,
        S_CONV   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(NBIT - 1);
    localparam logic [3:0] SMP_LAST = 4'(SAMPLE_CYC - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        k_q, k_d;
    logic              smp_q, smp_d;
    logic [0:NBIT-1]   swp_q, swp_d;
    logic              final_q, final_d;
    logic              busy_q, busy_d;

    // State and output registers; RST clears everything without waiting for CKS.
    always_ff @(posedge CKS or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            k_q     <= 4'd0;
            smp_q   <= 1'b0;
            swp_q   <= '0;
            final_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            smp_q   <= smp_d;
            swp_q   <= swp_d;
            final_q <= final_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and next-output logic; strobes default low, SWP defaults to hold.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        smp_d   = 1'b0;
        swp_d   = swp_q;
        final_d = 1'b0;
        busy_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (EN) begin
                    state_d = S_SAMPLE;
                    smp_d   = 1'b1;
                    busy_d  = 1'b1;
                    swp_d   = '0;
                    cnt_d   = 4'd0;
                    k_d     = 4'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SAMPLE: begin
                swp_d = '0;
                if (!EN) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q >= SMP_LAST) begin
                    state_d  = S_CONV;
                    busy_d   = 1'b1;
                    swp_d[0] = 1'b1;
                    k_d      = 4'd0;
                    cnt_d    = 4'd0;
                end else begin
                    cnt_d  = cnt_q + 4'd1;
                    smp_d  = 1'b1;
                    busy_d = 1'b1;
                end
            end
            S_CONV: begin
                // Abort wins over the last decision so a partial word never gets FINAL.
                if (!EN) begin
                    state_d = S_IDLE;
                    swp_d   = '0;
                    k_d     = 4'd0;
                end else begin
                    swp_d[k_q] = CMP;
                    if (k_q >= LAST_BIT) begin
                        state_d = S_DONE;
                        final_d = 1'b1;
                        k_d     = 4'd0;
                    end else begin
                        swp_d[k_q + 4'd1] = 1'b1;
                        k_d               = k_q + 4'd1;
                        busy_d            = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (EN) begin
                    state_d = S_SAMPLE;
                    smp_d   = 1'b1;
                    busy_d  = 1'b1;
                    swp_d   = '0;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                swp_d   = '0;
                cnt_d   = 4'd0;
                k_d     = 4'd0;
            end
        endcase
    end

    assign SMP   = smp_q;
    assign SWP   = swp_q;
    assign FINAL = final_q;
    assign BUSY  = busy_q;

endmodule

// File: doc/sar_logic.md
# sar_logic

Successive-approximation controller for the 9-bit SAR ADC. It runs the sample phase, drives the capacitive-DAC switch word MSB-first from comparator decisions, and pulses FINAL once the word is complete. It sits in front of the output latch: SWP and FINAL from this block are the latch's SWP and FINAL inputs. The same CKS clock is used to gate the downstream clock.

## Interface
Parameters:
- NBIT, 9, conversion width. Fixed at 9 for this ADC; other values are not supported.
- SAMPLE_CYC, 2, sample-phase length in CKS cycles. Legal range 1..15.

Ports:
- CKS  input  1  conversion clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- EN  input  1  conversion enable, level-sensitive, sampled on CKS.
- CMP  input  1  comparator decision, synchronous to CKS. 1 = keep the current trial bit; 0 = clear it.
- SMP  output  1  sample-switch control, high during the sample phase.
- SWP  output  [0:8]  DAC switch word. SWP[0] is the MSB and SWP[8] is the LSB.
- FINAL  output  1  conversion-complete strobe, one CKS cycle wide.
- BUSY  output  1  high in SAMPLE and CONV.

## Operation
- All outputs are registered.
- Reset values: SMP=0, SWP=9'b0, FINAL=0, BUSY=0, state=IDLE, bit pointer k=0, sample counter=0.
- States: IDLE, SAMPLE, CONV, DONE.
- IDLE:
  - SWP holds the last result (0 after reset).
  - EN=1 → SAMPLE: SMP=1, BUSY=1, SWP cleared to 0, counter=0.
- SAMPLE:
  - SMP=1, SWP=0. The counter increments each cycle.
  - After SAMPLE_CYC cycles → CONV: SMP=0, SWP=9'b100000000, k=0.
  - EN=0 → IDLE with SMP=0 and SWP=0.
- CONV, one decision per cycle:
  - CMP=0 → clear SWP[k]; CMP=1 → keep SWP[k].
  - k<8 → set SWP[k+1]=1, k=k+1.
  - k=8 → DONE: FINAL=1, BUSY=0.
- DONE:
  - SWP is held; FINAL=1 for exactly this cycle.
  - Next edge: FINAL=0. EN=1 → SAMPLE (back-to-back); EN=0 → IDLE with SWP held.
- EN=0 during CONV → abort. Next state IDLE, SWP=0, BUSY=0, no FINAL pulse.
- Settled bits SWP[0..k-1] never change within a conversion. Bits above the trial bit are always 0.

## Timing
- Edge 0 is the CKS edge that samples EN=1 in IDLE.
- Edges 0..SAMPLE_CYC-1: SMP high. SMP goes low at edge SAMPLE_CYC, together with SWP=100000000.
- Decisions at edges SAMPLE_CYC+1 .. SAMPLE_CYC+9 resolve bits 0..8.
- FINAL rises at edge SAMPLE_CYC+9 and falls at edge SAMPLE_CYC+10.
- SWP is stable from edge SAMPLE_CYC+9 until at least edge SAMPLE_CYC+10. The latch's rising-edge capture on FINAL therefore sees the final word.
- Back-to-back throughput: one conversion per SAMPLE_CYC+10 cycles (12 at the default). FINAL pulses are separated by SAMPLE_CYC+9 low cycles.
- CMP must be stable at each rising CKS edge during CONV. The comparator is strobed externally and has one full cycle to settle on each trial word.
- RST asserted at any point forces reset values immediately, without waiting for a clock edge. A partial word is never flagged with FINAL.
- After RST deasserts, the first conversion starts at the first edge that samples EN=1.

## Test plan
- Defaults, EN=1 for one conversion, CMP=1 every decision:
  - SWP walks 100000000 → 110000000 → … → 111111111.
  - FINAL is high at edge 11 only.
  - SMP is high at edges 0–1.
- CMP sequence 1,0,1,1,0,0,1,1,0 → SWP=101100110 at FINAL. CMP=0 throughout → SWP=000000000 with FINAL still pulsed.
- EN held high for 3 conversions with alternating CMP patterns:
  - FINAL pulses at edges 11, 23, 35.
  - SWP clears to 0 at edges 12 and 24.
  - BUSY drops only at edges 11, 23, 35.
- EN deasserted while k=4 → next edge state IDLE, SWP=0, BUSY=0, and no FINAL pulse ever appears.
- RST pulsed mid-CONV, asynchronously between edges:
  - All outputs go to reset values before the next edge.
  - Re-asserting EN gives a full 12-cycle conversion with the correct word.
- SAMPLE_CYC=1 → SMP high for one cycle only, FINAL at edge 10, back-to-back period 11 cycles.
